// File: rtl/decode_execute_register.sv
// Decode/execute pipeline register with flush, hold and bubble control.
// Also keeps a saturating count of the NOP entries it inserts.
module decode_execute_register (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        hold,
  input  logic        bubble,
  input  logic        d_valid,
  input  logic [31:0] d_pc,
  input  logic [31:0] d_rs1_data,
  input  logic [31:0] d_rs2_data,
  input  logic [31:0] d_immediate,
  input  logic [4:0]  d_rs1_addr,
  input  logic [4:0]  d_rs2_addr,
  input  logic [4:0]  d_rd_addr,
  input  logic [2:0]  d_funct3,
  input  logic        d_funct7_bit,
  input  logic        d_write,
  input  logic        d_store,
  input  logic        d_load,
  input  logic        d_branch,
  input  logic [1:0]  d_alu_operand_a_selector,
  input  logic        d_alu_operand_b_selector,
  input  logic [1:0]  d_next_pc_selector,
  input  logic [2:0]  d_alu_operations_selector,
  output logic        q_valid,
  output logic [31:0] q_pc,
  output logic [31:0] q_rs1_data,
  output logic [31:0] q_rs2_data,
  output logic [31:0] q_immediate,
  output logic [4:0]  q_rs1_addr,
  output logic [4:0]  q_rs2_addr,
  output logic [4:0]  q_rd_addr,
  output logic [2:0]  q_funct3,
  output logic        q_funct7_bit,
  output logic        q_write,
  output logic        q_store,
  output logic        q_load,
  output logic        q_branch,
  output logic [1:0]  q_alu_operand_a_selector,
  output logic        q_alu_operand_b_selector,
  output logic [1:0]  q_next_pc_selector,
  output logic [2:0]  q_alu_operations_selector,
  output logic        load_rd_pending,
  output logic [15:0] bubble_count
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] immediate;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [2:0]  funct3;
    logic        funct7_bit;
    logic        write;
    logic        store;
    logic        load;
    logic        branch;
    logic [1:0]  a_sel;
    logic        b_sel;
    logic [1:0]  next_pc_sel;
    logic [2:0]  alu_op;
  } entry_t;

  entry_t      entry_q, entry_d, load_entry;
  logic [15:0] bubble_count_q, bubble_count_d;
  logic        insert_nop;

  // An invalid decode slot still carries its datapath fields, but its
  // side-effecting control bits are forced low so execute treats it as a NOP.
  always_comb begin
    load_entry             = '0;
    load_entry.valid       = d_valid;
    load_entry.pc          = d_pc;
    load_entry.rs1_data    = d_rs1_data;
    load_entry.rs2_data    = d_rs2_data;
    load_entry.immediate   = d_immediate;
    load_entry.rs1_addr    = d_rs1_addr;
    load_entry.rs2_addr    = d_rs2_addr;
    load_entry.rd_addr     = d_rd_addr;
    load_entry.funct3      = d_funct3;
    load_entry.funct7_bit  = d_funct7_bit;
    load_entry.write       = d_write  & d_valid;
    load_entry.store       = d_store  & d_valid;
    load_entry.load        = d_load   & d_valid;
    load_entry.branch      = d_branch & d_valid;
    load_entry.a_sel       = d_alu_operand_a_selector;
    load_entry.b_sel       = d_alu_operand_b_selector;
    load_entry.next_pc_sel = d_next_pc_selector;
    load_entry.alu_op      = d_alu_operations_selector;
  end

  // Priority: flush > hold > bubble > normal load.
  always_comb begin
    entry_d    = entry_q;
    insert_nop = 1'b0;
    if (flush) begin
      entry_d    = '0;
      insert_nop = 1'b1;
    end else if (hold) begin
      entry_d    = entry_q;
    end else if (bubble) begin
      entry_d    = '0;
      insert_nop = 1'b1;
    end else begin
      entry_d    = load_entry;
      insert_nop = ~d_valid;
    end
  end

  always_comb begin
    bubble_count_d = bubble_count_q;
    if (insert_nop && (bubble_count_q != 16'hFFFF)) begin
      bubble_count_d = bubble_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q        <= '0;
      bubble_count_q <= '0;
    end else begin
      entry_q        <= entry_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign q_valid                   = entry_q.valid;
  assign q_pc                      = entry_q.pc;
  assign q_rs1_data                = entry_q.rs1_data;
  assign q_rs2_data                = entry_q.rs2_data;
  assign q_immediate               = entry_q.immediate;
  assign q_rs1_addr                = entry_q.rs1_addr;
  assign q_rs2_addr                = entry_q.rs2_addr;
  assign q_rd_addr                 = entry_q.rd_addr;
  assign q_funct3                  = entry_q.funct3;
  assign q_funct7_bit              = entry_q.funct7_bit;
  assign q_write                   = entry_q.write;
  assign q_store                   = entry_q.store;
  assign q_load                    = entry_q.load;
  assign q_branch                  = entry_q.branch;
  assign q_alu_operand_a_selector  = entry_q.a_sel;
  assign q_alu_operand_b_selector  = entry_q.b_sel;
  assign q_next_pc_selector        = entry_q.next_pc_sel;
  assign q_alu_operations_selector = entry_q.alu_op;
  assign bubble_count              = bubble_count_q;

  assign load_rd_pending = entry_q.valid & entry_q.load & (entry_q.rd_addr != 5'd0);

endmodule

// File: tb/tb_decode_execute_register.sv
// Directed bench for decode_execute_register: reset, load, hold, bubble,
// flush, mid-hold reset and bubble counter saturation.
module tb_decode_execute_register;

  logic        clk = 1'b0;
  logic        rst, flush, hold, bubble, d_valid;
  logic [31:0] d_pc, d_rs1_data, d_rs2_data, d_immediate;
  logic [4:0]  d_rs1_addr, d_rs2_addr, d_rd_addr;
  logic [2:0]  d_funct3;
  logic        d_funct7_bit, d_write, d_store, d_load, d_branch;
  logic [1:0]  d_alu_operand_a_selector;
  logic        d_alu_operand_b_selector;
  logic [1:0]  d_next_pc_selector;
  logic [2:0]  d_alu_operations_selector;

  logic        q_valid;
  logic [31:0] q_pc, q_rs1_data, q_rs2_data, q_immediate;
  logic [4:0]  q_rs1_addr, q_rs2_addr, q_rd_addr;
  logic [2:0]  q_funct3;
  logic        q_funct7_bit, q_write, q_store, q_load, q_branch;
  logic [1:0]  q_alu_operand_a_selector;
  logic        q_alu_operand_b_selector;
  logic [1:0]  q_next_pc_selector;
  logic [2:0]  q_alu_operations_selector;
  logic        load_rd_pending;
  logic [15:0] bubble_count;

  logic [159:0] q_all;
  assign q_all = {q_valid, q_pc, q_rs1_data, q_rs2_data, q_immediate,
                  q_rs1_addr, q_rs2_addr, q_rd_addr, q_funct3, q_funct7_bit,
                  q_write, q_store, q_load, q_branch, q_alu_operand_a_selector,
                  q_alu_operand_b_selector, q_next_pc_selector,
                  q_alu_operations_selector};

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_count = 16'd0;

  decode_execute_register dut (
    .clk(clk), .rst(rst), .flush(flush), .hold(hold), .bubble(bubble),
    .d_valid(d_valid), .d_pc(d_pc), .d_rs1_data(d_rs1_data),
    .d_rs2_data(d_rs2_data), .d_immediate(d_immediate),
    .d_rs1_addr(d_rs1_addr), .d_rs2_addr(d_rs2_addr), .d_rd_addr(d_rd_addr),
    .d_funct3(d_funct3), .d_funct7_bit(d_funct7_bit), .d_write(d_write),
    .d_store(d_store), .d_load(d_load), .d_branch(d_branch),
    .d_alu_operand_a_selector(d_alu_operand_a_selector),
    .d_alu_operand_b_selector(d_alu_operand_b_selector),
    .d_next_pc_selector(d_next_pc_selector),
    .d_alu_operations_selector(d_alu_operations_selector),
    .q_valid(q_valid), .q_pc(q_pc), .q_rs1_data(q_rs1_data),
    .q_rs2_data(q_rs2_data), .q_immediate(q_immediate),
    .q_rs1_addr(q_rs1_addr), .q_rs2_addr(q_rs2_addr), .q_rd_addr(q_rd_addr),
    .q_funct3(q_funct3), .q_funct7_bit(q_funct7_bit), .q_write(q_write),
    .q_store(q_store), .q_load(q_load), .q_branch(q_branch),
    .q_alu_operand_a_selector(q_alu_operand_a_selector),
    .q_alu_operand_b_selector(q_alu_operand_b_selector),
    .q_next_pc_selector(q_next_pc_selector),
    .q_alu_operations_selector(q_alu_operations_selector),
    .load_rd_pending(load_rd_pending), .bubble_count(bubble_count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one decode slot; non-argument fields use fixed known constants.
  task automatic drive(input logic v, input logic [31:0] pc,
                       input logic [4:0] rd, input logic ld);
    d_valid                   = v;
    d_pc                      = pc;
    d_rd_addr                 = rd;
    d_load                    = ld;
    d_rs1_data                = 32'h1111_1111;
    d_rs2_data                = 32'h2222_2222;
    d_immediate               = 32'h0000_0ABC;
    d_rs1_addr                = 5'd1;
    d_rs2_addr                = 5'd2;
    d_funct3                  = 3'b010;
    d_funct7_bit              = 1'b1;
    d_write                   = 1'b1;
    d_store                   = 1'b0;
    d_branch                  = 1'b0;
    d_alu_operand_a_selector  = 2'b01;
    d_alu_operand_b_selector  = 1'b1;
    d_next_pc_selector        = 2'b10;
    d_alu_operations_selector = 3'b101;
  endtask

  task automatic ctrl(input logic f, input logic h, input logic b);
    flush  = f;
    hold   = h;
    bubble = b;
  endtask

  // Tests
  task automatic test_reset();
    rst = 1'b1;
    ctrl(1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hDEAD_BEEF, 5'd9, 1'b1);
    step();
    step();
    checks++; if (q_all !== 160'd0) begin errors++;
      $display("FAIL reset_q: got %h expected 0", q_all); end
    checks++; if (bubble_count !== 16'd0) begin errors++;
      $display("FAIL reset_count: got %h expected 0", bubble_count); end
    checks++; if (load_rd_pending !== 1'b0) begin errors++;
      $display("FAIL reset_pending: got %b expected 0", load_rd_pending); end
    ctrl(1'b1, 1'b1, 1'b1);
    step();
    checks++; if (q_all !== 160'd0 || bubble_count !== 16'd0) begin errors++;
      $display("FAIL reset_override: q=%h count=%h expected 0", q_all, bubble_count); end
    ctrl(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_load();
    drive(1'b1, 32'h0000_0010, 5'd5, 1'b1);
    step();
    checks++; if (q_pc !== 32'h0000_0010) begin errors++;
      $display("FAIL load_pc: got %h expected 00000010", q_pc); end
    checks++; if (q_load !== 1'b1 || q_valid !== 1'b1 || q_write !== 1'b1) begin errors++;
      $display("FAIL load_ctrl: load=%b valid=%b write=%b expected 1 1 1", q_load, q_valid, q_write); end
    checks++; if (load_rd_pending !== 1'b1) begin errors++;
      $display("FAIL load_pending: got %b expected 1", load_rd_pending); end
    checks++; if ({q_rs1_data, q_rs2_data, q_immediate} !== {32'h1111_1111, 32'h2222_2222, 32'h0000_0ABC}) begin errors++;
      $display("FAIL load_data: got %h %h %h", q_rs1_data, q_rs2_data, q_immediate); end
    checks++; if ({q_rs1_addr, q_rs2_addr, q_rd_addr, q_funct3, q_funct7_bit} !== {5'd1, 5'd2, 5'd5, 3'b010, 1'b1}) begin errors++;
      $display("FAIL load_fields: rs1=%0d rs2=%0d rd=%0d f3=%b f7=%b", q_rs1_addr, q_rs2_addr, q_rd_addr, q_funct3, q_funct7_bit); end
    checks++; if ({q_alu_operand_a_selector, q_alu_operand_b_selector, q_next_pc_selector, q_alu_operations_selector} !== {2'b01, 1'b1, 2'b10, 3'b101}) begin errors++;
      $display("FAIL load_sel: a=%b b=%b npc=%b op=%b", q_alu_operand_a_selector, q_alu_operand_b_selector, q_next_pc_selector, q_alu_operations_selector); end
    checks++; if (bubble_count !== exp_count) begin errors++;
      $display("FAIL load_count: got %h expected %h", bubble_count, exp_count); end
  endtask

  task automatic test_hold();
    ctrl(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h0000_0020 + 32'(i) * 32'h10, 5'd6, 1'b0);
      bubble = (i == 1);
      step();
      checks++; if (q_pc !== 32'h0000_0010 || q_rd_addr !== 5'd5) begin errors++;
        $display("FAIL hold_pc[%0d]: pc=%h rd=%0d expected 00000010 5", i, q_pc, q_rd_addr); end
      checks++; if (bubble_count !== exp_count) begin errors++;
        $display("FAIL hold_count[%0d]: got %h expected %h", i, bubble_count, exp_count); end
    end
    ctrl(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_invalid_load();
    drive(1'b0, 32'h0000_0044, 5'd7, 1'b1);
    d_store  = 1'b1;
    d_branch = 1'b1;
    step();
    exp_count = exp_count + 16'd1;
    checks++; if ({q_valid, q_write, q_store, q_load, q_branch} !== 5'b00000) begin errors++;
      $display("FAIL invalid_ctrl: v/w/s/l/b=%b%b%b%b%b expected 00000", q_valid, q_write, q_store, q_load, q_branch); end
    checks++; if (q_pc !== 32'h0000_0044 || q_rd_addr !== 5'd7 || q_alu_operations_selector !== 3'b101) begin errors++;
      $display("FAIL invalid_fields: pc=%h rd=%0d op=%b expected 00000044 7 101", q_pc, q_rd_addr, q_alu_operations_selector); end
    checks++; if (load_rd_pending !== 1'b0) begin errors++;
      $display("FAIL invalid_pending: got %b expected 0", load_rd_pending); end
    checks++; if (bubble_count !== exp_count) begin errors++;
      $display("FAIL invalid_count: got %h expected %h", bubble_count, exp_count); end
  endtask

  task automatic test_bubble();
    drive(1'b1, 32'h0000_0050, 5'd3, 1'b1);
    ctrl(1'b0, 1'b0, 1'b1);
    step();
    exp_count = exp_count + 16'd1;
    checks++; if (q_all !== 160'd0) begin errors++;
      $display("FAIL bubble_q: got %h expected 0", q_all); end
    checks++; if (bubble_count !== exp_count) begin errors++;
      $display("FAIL bubble_count: got %h expected %h", bubble_count, exp_count); end
    drive(1'b1, 32'h0000_0060, 5'd4, 1'b0);
    ctrl(1'b0, 1'b0, 1'b0);
    step();
    checks++; if (q_pc !== 32'h0000_0060 || q_valid !== 1'b1 || bubble_count !== exp_count) begin errors++;
      $display("FAIL bubble_reload: pc=%h valid=%b count=%h expected 00000060 1 %h", q_pc, q_valid, bubble_count, exp_count); end
    drive(1'b1, 32'h0000_0064, 5'd4, 1'b0);
    ctrl(1'b0, 1'b1, 1'b1);
    step();
    checks++; if (q_pc !== 32'h0000_0060 || q_valid !== 1'b1 || bubble_count !== exp_count) begin errors++;
      $display("FAIL bubble_hold: pc=%h valid=%b count=%h expected 00000060 1 %h", q_pc, q_valid, bubble_count, exp_count); end
    ctrl(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h0000_0068, 5'd8, 1'b1);
    ctrl(1'b1, 1'b1, 1'b1);
    step();
    exp_count = exp_count + 16'd1;
    checks++; if (q_all !== 160'd0) begin errors++;
      $display("FAIL flush_q: got %h expected 0", q_all); end
    checks++; if (bubble_count !== exp_count) begin errors++;
      $display("FAIL flush_count: got %h expected %h", bubble_count, exp_count); end
    drive(1'b1, 32'h0000_0070, 5'd8, 1'b1);
    ctrl(1'b0, 1'b0, 1'b0);
    step();
    checks++; if (q_pc !== 32'h0000_0070 || load_rd_pending !== 1'b1 || bubble_count !== exp_count) begin errors++;
      $display("FAIL flush_after: pc=%h pend=%b count=%h expected 00000070 1 %h", q_pc, load_rd_pending, bubble_count, exp_count); end
  endtask

  task automatic test_reset_mid();
    ctrl(1'b0, 1'b1, 1'b0);
    step();
    #2 rst = 1'b1;
    #1;
    checks++; if (q_all !== 160'd0 || bubble_count !== 16'd0 || load_rd_pending !== 1'b0) begin errors++;
      $display("FAIL async_reset: q=%h count=%h pend=%b expected 0", q_all, bubble_count, load_rd_pending); end
    rst = 1'b0;
    exp_count = 16'd0;
    step();
    checks++; if (q_all !== 160'd0 || bubble_count !== exp_count) begin errors++;
      $display("FAIL hold_after_reset: q=%h count=%h expected 0", q_all, bubble_count); end
    drive(1'b1, 32'h0000_0080, 5'd0, 1'b1);
    ctrl(1'b0, 1'b0, 1'b0);
    step();
    checks++; if (q_pc !== 32'h0000_0080 || q_load !== 1'b1 || load_rd_pending !== 1'b0) begin errors++;
      $display("FAIL rd0_pending: pc=%h load=%b pend=%b expected 00000080 1 0", q_pc, q_load, load_rd_pending); end
  endtask

  task automatic test_saturate();
    ctrl(1'b0, 1'b0, 1'b1);
    repeat (int'(16'hFFFE - exp_count)) @(posedge clk);
    #1;
    exp_count = 16'hFFFE;
    checks++; if (bubble_count !== exp_count) begin errors++;
      $display("FAIL sat_pre: got %h expected %h", bubble_count, exp_count); end
    step();
    checks++; if (bubble_count !== 16'hFFFF) begin errors++;
      $display("FAIL sat_max: got %h expected ffff", bubble_count); end
    step();
    step();
    checks++; if (bubble_count !== 16'hFFFF) begin errors++;
      $display("FAIL sat_hold: got %h expected ffff", bubble_count); end
    ctrl(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_load();
    test_hold();
    test_invalid_load();
    test_bubble();
    test_flush();
    test_reset_mid();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
